// File: rtl/chain_score_pipe.sv
// Six-stage flow-controlled anchor-pair chaining score: min(min(dr,dq),w) - gap_cost.
// Define CHAIN_SCORE_SAT_EN to saturate the score instead of wrapping it.
module chain_score_pipe #(
  parameter int unsigned DW       = 32,
  parameter int unsigned TAG_W    = 16,
  parameter int unsigned MAX_DIST = 5000,
  parameter int unsigned BW       = 500
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    ri_x,
  input  logic [DW-1:0]    ri_y,
  input  logic [DW-1:0]    qi_x,
  input  logic [DW-1:0]    qi_y,
  input  logic [DW-1:0]    w,
  input  logic [DW-1:0]    w_avg,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    score,
  output logic             keep,
  output logic [TAG_W-1:0] out_tag
);

  localparam int unsigned PW = 2 * DW;
  localparam int unsigned LW = $clog2(DW);
  localparam int unsigned CW = (DW > 32) ? DW : 32;

  typedef struct packed {
    logic             valid;
    logic [DW-1:0]    dr;
    logic [DW-1:0]    dq;
    logic [DW-1:0]    w;
    logic [DW-1:0]    wavg;
    logic [TAG_W-1:0] tag;
  } s1_t;

  typedef struct packed {
    logic             valid;
    logic [DW-1:0]    dd;
    logic [DW-1:0]    mn;
    logic [DW-1:0]    w;
    logic [DW-1:0]    wavg;
    logic             rej;
    logic [TAG_W-1:0] tag;
  } s2_t;

  typedef struct packed {
    logic             valid;
    logic [DW-1:0]    a;
    logic [PW-1:0]    prod;
    logic [DW-1:0]    dd;
    logic             rej;
    logic [TAG_W-1:0] tag;
  } s3_t;

  typedef struct packed {
    logic             valid;
    logic [DW-1:0]    a;
    logic [DW-1:0]    q;
    logic [LW-1:0]    lg;
    logic             ddz;
    logic             rej;
    logic [TAG_W-1:0] tag;
  } s4_t;

  typedef struct packed {
    logic             valid;
    logic [DW-1:0]    a;
    logic [DW-1:0]    b;
    logic             rej;
    logic [TAG_W-1:0] tag;
  } s5_t;

  typedef struct packed {
    logic             valid;
    logic [DW-1:0]    score;
    logic             keep;
    logic [TAG_W-1:0] tag;
  } s6_t;

  s1_t s1_d, s1_q;
  s2_t s2_d, s2_q;
  s3_t s3_d, s3_q;
  s4_t s4_d, s4_q;
  s5_t s5_d, s5_q;
  s6_t s6_d, s6_q;

  logic               en;
  logic [PW-1:0]      quot;
  logic [LW-1:0]      lg;
  logic [DW:0]        sum;
  logic signed [DW+1:0] d;
`ifdef CHAIN_SCORE_SAT_EN
  logic               fits;
`endif

  assign en       = !s6_q.valid || out_ready;
  assign in_ready = en;

  always_comb begin
    s1_d.valid = in_valid;
    s1_d.dr    = (ri_x >= ri_y) ? ri_x - ri_y : ri_y - ri_x;
    s1_d.dq    = (qi_x >= qi_y) ? qi_x - qi_y : qi_y - qi_x;
    s1_d.w     = w;
    s1_d.wavg  = w_avg;
    s1_d.tag   = in_tag;

    s2_d.valid = s1_q.valid;
    s2_d.dd    = (s1_q.dr >= s1_q.dq) ? s1_q.dr - s1_q.dq : s1_q.dq - s1_q.dr;
    s2_d.mn    = (s1_q.dr < s1_q.dq) ? s1_q.dr : s1_q.dq;
    s2_d.w     = s1_q.w;
    s2_d.wavg  = s1_q.wavg;
    s2_d.rej   = (s1_q.dr == '0) || (s1_q.dq == '0) ||
                 (CW'(s1_q.dr) > CW'(MAX_DIST)) || (CW'(s1_q.dq) > CW'(MAX_DIST));
    s2_d.tag   = s1_q.tag;

    s3_d.valid = s2_q.valid;
    s3_d.a     = (s2_q.mn < s2_q.w) ? s2_q.mn : s2_q.w;
    s3_d.prod  = PW'(s2_q.dd) * PW'(s2_q.wavg);
    s3_d.dd    = s2_q.dd;
    s3_d.rej   = s2_q.rej || (CW'(s2_q.dd) > CW'(BW));
    s3_d.tag   = s2_q.tag;

    // Highest set bit of dd; stays 0 for dd of 0 or 1.
    quot = s3_q.prod / PW'(100);
    lg   = '0;
    for (int i = 0; i < DW; i++) begin
      if (s3_q.dd[i]) lg = LW'(i);
    end
    s4_d.valid = s3_q.valid;
    s4_d.a     = s3_q.a;
    s4_d.q     = (|quot[PW-1:DW]) ? {DW{1'b1}} : quot[DW-1:0];
    s4_d.lg    = lg;
    s4_d.ddz   = (s3_q.dd == '0);
    s4_d.rej   = s3_q.rej;
    s4_d.tag   = s3_q.tag;

    sum        = {1'b0, s4_q.q} + (DW+1)'(s4_q.lg >> 1);
    s5_d.valid = s4_q.valid;
    s5_d.a     = s4_q.a;
    s5_d.b     = s4_q.ddz ? '0 : (sum[DW] ? {DW{1'b1}} : sum[DW-1:0]);
    s5_d.rej   = s4_q.rej;
    s5_d.tag   = s4_q.tag;

    d          = {2'b00, s5_q.a} - {2'b00, s5_q.b};
    s6_d.valid = s5_q.valid;
`ifdef CHAIN_SCORE_SAT_EN
    fits = (d[DW+1:DW-1] == 3'b000) || (d[DW+1:DW-1] == 3'b111);
    if (fits)        s6_d.score = d[DW-1:0];
    else if (d[DW+1]) s6_d.score = {1'b1, {(DW-1){1'b0}}};
    else             s6_d.score = {1'b0, {(DW-1){1'b1}}};
`else
    s6_d.score = d[DW-1:0];
`endif
    s6_d.keep  = !s5_q.rej;
    s6_d.tag   = s5_q.tag;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
      s4_q <= '0;
      s5_q <= '0;
      s6_q <= '0;
    end else if (en) begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
      s4_q <= s4_d;
      s5_q <= s5_d;
      s6_q <= s6_d;
    end
  end

  assign out_valid = s6_q.valid;
  assign score     = s6_q.score;
  assign keep      = s6_q.keep;
  assign out_tag   = s6_q.tag;

endmodule

// File: tb/tb_chain_score_pipe.sv
// Bench for chain_score_pipe: directed vectors plus random traffic against a reference model,
// on a 32-bit instance with backpressure and a 12-bit instance that always drains.
module tb_chain_score_pipe;

  typedef struct {
    logic [31:0] rx, ry, qx, qy, w, wa;
    logic [15:0] tag;
  } beat_t;

  typedef struct {
    logic [63:0] sc;
    logic        kp;
    logic [15:0] tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, in_valid, out_ready;
  logic [31:0] ri_x, ri_y, qi_x, qi_y, w, w_avg;
  logic [15:0] in_tag;

  logic        in_ready, out_valid, keep;
  logic [31:0] score;
  logic [15:0] out_tag;
  logic        in_ready_s, out_valid_s, keep_s;
  logic [11:0] score_s;
  logic [15:0] out_tag_s;

  int checks = 0, failures = 0, emitted = 0;
  bit last_acc;
  exp_t q32[$], q12[$];

  always #5 clk = ~clk;

  chain_score_pipe #(.DW(32), .TAG_W(16), .MAX_DIST(5000), .BW(500)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .ri_x(ri_x), .ri_y(ri_y), .qi_x(qi_x), .qi_y(qi_y), .w(w), .w_avg(w_avg),
    .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .score(score), .keep(keep), .out_tag(out_tag)
  );

  chain_score_pipe #(.DW(12), .TAG_W(16), .MAX_DIST(4095), .BW(4095)) u_dut_s (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_s),
    .ri_x(ri_x[11:0]), .ri_y(ri_y[11:0]), .qi_x(qi_x[11:0]), .qi_y(qi_y[11:0]),
    .w(w[11:0]), .w_avg(w_avg[11:0]), .in_tag(in_tag), .out_valid(out_valid_s),
    .out_ready(1'b1), .score(score_s), .keep(keep_s), .out_tag(out_tag_s)
  );

  task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Score rule evaluated with plain 64-bit arithmetic at coordinate width dw.
  function automatic exp_t model(input int dw, input longint unsigned maxd,
                                 input longint unsigned bw, input beat_t b);
    exp_t e;
    longint unsigned mask, rx, ry, qx, qy, wv, wa, dr, dq, dd, mn, a, q, bb;
    longint d, lim;
    int lg;
    bit rej;
    mask = (64'd1 << dw) - 64'd1;
    rx = b.rx & mask; ry = b.ry & mask; qx = b.qx & mask; qy = b.qy & mask;
    wv = b.w & mask;  wa = b.wa & mask;
    dr = (rx > ry) ? rx - ry : ry - rx;
    dq = (qx > qy) ? qx - qy : qy - qx;
    dd = (dr > dq) ? dr - dq : dq - dr;
    mn = (dr < dq) ? dr : dq;
    rej = (dr == 0) || (dq == 0) || (dr > maxd) || (dq > maxd) || (dd > bw);
    a = (mn < wv) ? mn : wv;
    q = (dd * wa) / 100;
    if (q > mask) q = mask;
    lg = 0;
    for (int i = 0; i < dw; i++) if (dd >= (64'd1 << i)) lg = i;
    bb = (dd == 0) ? 0 : q + longint'(lg / 2);
    if (bb > mask) bb = mask;
    d = longint'(a) - longint'(bb);
    lim = longint'(1) << (dw - 1);
`ifdef CHAIN_SCORE_SAT_EN
    if (d > lim - 1) d = lim - 1;
    if (d < -lim) d = -lim;
`endif
    e.sc  = 64'(d) & mask;
    e.kp  = !rej;
    e.tag = b.tag;
    return e;
  endfunction

  function automatic beat_t mk(input logic [31:0] rx, ry, qx, qy, wv, wa, input logic [15:0] tag);
    beat_t b;
    b.rx = rx; b.ry = ry; b.qx = qx; b.qy = qy; b.w = wv; b.wa = wa; b.tag = tag;
    return b;
  endfunction

  function automatic beat_t rand_beat(input logic [15:0] tag);
    beat_t b;
    logic [31:0] span, t;
    if ($urandom_range(0, 3) == 0) begin
      b = mk($urandom, $urandom, $urandom, $urandom, $urandom, $urandom, tag);
    end else begin
      span = $urandom_range(0, 6000);
      b.rx = $urandom_range(0, 100000);
      b.ry = b.rx + span;
      b.qx = $urandom_range(0, 100000);
      b.qy = b.qx + span + $urandom_range(0, 800) - 32'd400;
      if ($urandom_range(0, 1) == 1) begin t = b.rx; b.rx = b.ry; b.ry = t; end
      b.w   = $urandom_range(0, 300);
      b.wa  = $urandom_range(0, 400);
      b.tag = tag;
    end
    return b;
  endfunction

  task automatic drive(input bit v, input bit ordy, input beat_t b);
    in_valid = v; out_ready = ordy;
    ri_x = b.rx; ri_y = b.ry; qi_x = b.qx; qi_y = b.qy; w = b.w; w_avg = b.wa; in_tag = b.tag;
  endtask

  // One cycle: drive at negedge, then observe the handshakes the next posedge will perform.
  task automatic step(input bit v, input bit ordy, input beat_t b);
    exp_t e;
    @(negedge clk);
    drive(v, ordy, b);
    #1;
    check_eq("in_ready", in_ready, !out_valid || out_ready);
    if (out_valid && out_ready) begin
      emitted++;
      if (q32.size() == 0) check_eq("unexpected_out", out_valid, 0);
      else begin
        e = q32.pop_front();
        check_eq("score", score, e.sc);
        check_eq("keep", keep, e.kp);
        check_eq("tag", out_tag, e.tag);
      end
    end
    if (out_valid_s) begin
      if (q12.size() == 0) check_eq("unexpected_out12", out_valid_s, 0);
      else begin
        e = q12.pop_front();
        check_eq("score12", score_s, e.sc);
        check_eq("keep12", keep_s, e.kp);
        check_eq("tag12", out_tag_s, e.tag);
      end
    end
    last_acc = in_valid && in_ready;
    if (last_acc) q32.push_back(model(32, 5000, 500, b));
    if (in_valid && in_ready_s) q12.push_back(model(12, 4095, 4095, b));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    q32.delete(); q12.delete();
  endtask

  task automatic directed(input string nm, input bit sel, input beat_t b,
                          input logic [63:0] esc, input bit ekp);
    int lat;
    @(negedge clk);
    drive(1'b1, 1'b1, b);
    #1 check_eq({nm, "_accept"}, in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (((sel ? out_valid_s : out_valid) == 1'b0) && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check_eq({nm, "_latency"}, lat, 6);
    check_eq({nm, "_score"}, sel ? 64'(score_s) : 64'(score), esc);
    check_eq({nm, "_keep"}, sel ? keep_s : keep, ekp);
    check_eq({nm, "_tag"}, sel ? out_tag_s : out_tag, b.tag);
  endtask

  initial begin
    beat_t b;
    int sent, cyc;
    b = mk(0, 0, 0, 0, 0, 0, 0);
    drive(1'b0, 1'b0, b);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_score", score, 0);
    check_eq("rst_keep", keep, 0);
    check_eq("rst_tag", out_tag, 0);
    check_eq("rst_in_ready", in_ready, 1);
    do_reset();

    directed("nominal", 0, mk(1000, 900, 500, 420, 15, 20, 16'h11), 64'd9, 1);
    directed("zero_gap", 0, mk(300, 250, 80, 30, 30, 50, 16'h22), 64'd30, 1);
    directed("dq_zero", 0, mk(20, 10, 70, 70, 5, 100, 16'h33), 64'hFFFF_FFF5, 0);
    directed("dd_over_bw", 0, mk(1000, 0, 1, 0, 1, 100, 16'h44), 64'hFFFF_FC16, 0);
    directed("dd_wide_bw", 1, mk(1000, 0, 1, 0, 1, 100, 16'h55), 64'hC16, 1);
    directed("dist_5000", 0, mk(5000, 0, 4800, 0, 10, 10, 16'h66), 64'hFFFF_FFF3, 1);
    directed("dist_5001", 0, mk(5001, 0, 4801, 0, 10, 10, 16'h77), 64'hFFFF_FFF3, 0);
    directed("bw_500", 0, mk(600, 0, 100, 0, 50, 0, 16'h88), 64'd46, 1);
    directed("bw_501", 0, mk(600, 0, 99, 0, 50, 0, 16'h99), 64'd46, 0);
`ifdef CHAIN_SCORE_SAT_EN
    directed("underflow12", 1, mk(2000, 0, 1, 0, 1, 200, 16'hAA), 64'h800, 1);
`else
    directed("underflow12", 1, mk(2000, 0, 1, 0, 1, 200, 16'hAA), 64'h05E, 1);
`endif

    // Backpressure: 8 tagged beats with out_ready low for 5 cycles while results are pending.
    do_reset();
    emitted = 0; sent = 0; cyc = 0;
    while ((sent < 8 || q32.size() > 0) && cyc < 100) begin
      step(sent < 8, !(cyc >= 7 && cyc < 12), rand_beat(16'(sent)));
      if (last_acc) sent++;
      cyc++;
    end
    check_eq("bp_emitted", emitted, 8);
    check_eq("bp_pending", q32.size(), 0);

    // Reset mid-stream discards everything in flight.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, rand_beat(16'(100 + i)));
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    check_eq("midrst_valid", out_valid, 0);
    check_eq("midrst_valid12", out_valid_s, 0);
    reset = 1'b0;
    q32.delete(); q12.delete();
    emitted = 0;
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1, b);
    check_eq("midrst_stale", emitted, 0);

    // Random traffic with random backpressure.
    do_reset();
    for (int i = 0; i < 800; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, rand_beat(16'($urandom)));
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, b);
    check_eq("rand_pending", q32.size(), 0);
    check_eq("rand_pending12", q12.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
